// File: rtl/brm_rate_mult.sv
// Binary rate multiplier: one shared up-counter drives CHANNELS pulse outputs with double-buffered rates.
// Optional per-channel pulse-count readback (PCNT) is enabled by defining BRM_PULSE_CNT_EN.
module brm_rate_mult #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 1,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CK,
    input  logic                      RN,
    input  logic                      Clear,
    input  logic                      X,
    input  logic                      RATE_WR,
    input  logic [CHW-1:0]            RATE_CH,
    input  logic [WIDTH-1:0]          RATE_D,
    output logic [CHANNELS-1:0]       Z,
    output logic                      W,
    output logic [CHANNELS-1:0]       RATE_PEND,
    output logic [WIDTH-1:0]          Y
`ifdef BRM_PULSE_CNT_EN
    ,
    output logic [CHANNELS*WIDTH-1:0] PCNT
`endif
);

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [CHANNELS-1:0] pend;

    logic [WIDTH-1:0]    low_zero;
    logic [WIDTH-1:0]    sel_mask;
    logic                cnt_full;
    logic                apply;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] z_next;

    // The lowest zero bit k of cnt selects rate bit WIDTH-1-k, so bit-reverse the one-hot mask.
    always_comb begin
        low_zero = ~cnt & (cnt + WIDTH'(1));
        sel_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sel_mask[WIDTH-1-i] = low_zero[i];
        end
        cnt_full = &cnt;
        apply    = Clear | (X & cnt_full);
        wr_hit   = '0;
        z_next   = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            wr_hit[ch] = RATE_WR && (RATE_CH == CHW'(ch));
            z_next[ch] = X & ~Clear & ~cnt_full & (|(active[ch] & sel_mask));
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt <= '0;
            Z   <= '0;
            W   <= 1'b0;
        end else if (Clear) begin
            cnt <= '0;
            Z   <= '0;
            W   <= 1'b0;
        end else if (X) begin
            cnt <= cnt + WIDTH'(1);
            Z   <= z_next;
            W   <= cnt_full;
        end else begin
            Z   <= '0;
            W   <= 1'b0;
        end
    end

    // A write landing on the apply edge goes straight to active and leaves nothing pending.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pend <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow[ch] <= '0;
                active[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (apply) begin
                    if (wr_hit[ch]) begin
                        shadow[ch] <= RATE_D;
                        active[ch] <= RATE_D;
                    end else if (pend[ch]) begin
                        active[ch] <= shadow[ch];
                    end
                    pend[ch] <= 1'b0;
                end else if (wr_hit[ch]) begin
                    shadow[ch] <= RATE_D;
                    pend[ch]   <= 1'b1;
                end
            end
        end
    end

    assign Y         = cnt;
    assign RATE_PEND = pend;

`ifdef BRM_PULSE_CNT_EN
    logic [WIDTH-1:0]          acc [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] pcnt_q;

    // acc counts pulses as they are issued; the wrap edge snapshots it into PCNT.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pcnt_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc[ch] <= '0;
            end
        end else if (Clear) begin
            pcnt_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc[ch] <= '0;
            end
        end else if (X & cnt_full) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                pcnt_q[ch*WIDTH +: WIDTH] <= acc[ch] + WIDTH'(z_next[ch]);
                acc[ch]                   <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (z_next[ch]) begin
                    acc[ch] <= acc[ch] + WIDTH'(1);
                end
            end
        end
    end

    assign PCNT = pcnt_q;
`endif

endmodule

// File: tb/tb_brm_rate_mult.sv
// Self-checking bench for brm_rate_mult (WIDTH=4, CHANNELS=3): vector table plus scoreboarded sequences.
module tb_brm_rate_mult;

    logic        CK = 1'b0;
    logic        RN;
    logic        Clear;
    logic        X;
    logic        RATE_WR;
    logic [1:0]  RATE_CH;
    logic [3:0]  RATE_D;
    logic [2:0]  Z;
    logic        W;
    logic [2:0]  RATE_PEND;
    logic [3:0]  Y;
`ifdef BRM_PULSE_CNT_EN
    logic [11:0] PCNT;
`endif

    brm_rate_mult #(.WIDTH(4), .CHANNELS(3)) dut (
        .CK(CK),
        .RN(RN),
        .Clear(Clear),
        .X(X),
        .RATE_WR(RATE_WR),
        .RATE_CH(RATE_CH),
        .RATE_D(RATE_D),
        .Z(Z),
        .W(W),
        .RATE_PEND(RATE_PEND),
        .Y(Y)
`ifdef BRM_PULSE_CNT_EN
        ,
        .PCNT(PCNT)
`endif
    );

    always #5 CK = ~CK;

    typedef struct {
        logic       clear;
        logic       x;
        logic       wr;
        logic [1:0] ch;
        logic [3:0] d;
        logic [2:0] z;
        logic       w;
        logic [3:0] y;
        logic [2:0] pend;
    } vec_t;

    typedef struct {
        logic [2:0] z;
        logic       w;
        logic [3:0] y;
        logic [2:0] pend;
    } exp_t;

    exp_t       exp_q [$];
    vec_t       tbl [18];
    int         checks   = 0;
    int         failures = 0;
    int         exp_cnt  = 0;
    logic [3:0] exp_rate [3];
    int         pulses [3];

    function automatic vec_t mk(input logic clear, x, wr, input logic [1:0] ch, input logic [3:0] d,
                                input logic [2:0] z, input logic w, input logic [3:0] y, input logic [2:0] pend);
        vec_t v;
        v.clear = clear; v.x = x; v.wr = wr; v.ch = ch; v.d = d;
        v.z = z; v.w = w; v.y = y; v.pend = pend;
        return v;
    endfunction

    // Reference pulse rule: lowest zero bit k of the pre-increment count picks rate bit 3-k.
    function automatic logic brm_bit(input logic [3:0] rate, input int c);
        int k;
        if (c == 15) return 1'b0;
        k = 0;
        while (c[k]) k++;
        return rate[3-k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic check_output(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, actual Z=%0h expected an entry", name, Z);
            return;
        end
        e = exp_q.pop_front();
        check({name, ".Z"}, 32'(Z), 32'(e.z));
        check({name, ".W"}, 32'(W), 32'(e.w));
        check({name, ".Y"}, 32'(Y), 32'(e.y));
        check({name, ".PEND"}, 32'(RATE_PEND), 32'(e.pend));
        for (int i = 0; i < 3; i++) pulses[i] += int'(Z[i]);
    endtask

    task automatic apply_stimulus(input string name, input logic clear, x, wr, input logic [1:0] ch,
                                  input logic [3:0] d, input exp_t e);
        exp_q.push_back(e);
        Clear = clear; X = x; RATE_WR = wr; RATE_CH = ch; RATE_D = d;
        @(posedge CK);
        #1;
        check_output(name);
    endtask

    task automatic tick(input string name, input logic clear, x, wr, input logic [1:0] ch,
                        input logic [3:0] d, input logic [2:0] pend_exp);
        exp_t e;
        e.z = '0;
        e.w = 1'b0;
        e.pend = pend_exp;
        if (clear) begin
            exp_cnt = 0;
        end else if (x) begin
            for (int i = 0; i < 3; i++) e.z[i] = brm_bit(exp_rate[i], exp_cnt);
            e.w = (exp_cnt == 15);
            exp_cnt = (exp_cnt + 1) % 16;
        end
        e.y = 4'(exp_cnt);
        apply_stimulus(name, clear, x, wr, ch, d, e);
    endtask

    task automatic count(input string name, input int n, input logic [2:0] pend_exp);
        for (int i = 0; i < n; i++) tick(name, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, pend_exp);
    endtask

    task automatic check_idle(input string name);
        check({name, ".Z"}, 32'(Z), 32'd0);
        check({name, ".W"}, 32'(W), 32'd0);
        check({name, ".Y"}, 32'(Y), 32'd0);
        check({name, ".PEND"}, 32'(RATE_PEND), 32'd0);
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time expired, actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // rate 5 on ch0, Clear, then one full period: pulses after cnt=1,5,7,9,13, wrap after 15
        tbl[0]  = mk(0, 0, 1, 0, 5, 3'b000, 0, 4'd0,  3'b001);
        tbl[1]  = mk(1, 0, 0, 0, 0, 3'b000, 0, 4'd0,  3'b000);
        tbl[2]  = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd1,  3'b000);
        tbl[3]  = mk(0, 1, 0, 0, 0, 3'b001, 0, 4'd2,  3'b000);
        tbl[4]  = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd3,  3'b000);
        tbl[5]  = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd4,  3'b000);
        tbl[6]  = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd5,  3'b000);
        tbl[7]  = mk(0, 1, 0, 0, 0, 3'b001, 0, 4'd6,  3'b000);
        tbl[8]  = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd7,  3'b000);
        tbl[9]  = mk(0, 1, 0, 0, 0, 3'b001, 0, 4'd8,  3'b000);
        tbl[10] = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd9,  3'b000);
        tbl[11] = mk(0, 1, 0, 0, 0, 3'b001, 0, 4'd10, 3'b000);
        tbl[12] = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd11, 3'b000);
        tbl[13] = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd12, 3'b000);
        tbl[14] = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd13, 3'b000);
        tbl[15] = mk(0, 1, 0, 0, 0, 3'b001, 0, 4'd14, 3'b000);
        tbl[16] = mk(0, 1, 0, 0, 0, 3'b000, 0, 4'd15, 3'b000);
        tbl[17] = mk(0, 1, 0, 0, 0, 3'b000, 1, 4'd0,  3'b000);

        RN = 1'b0; Clear = 1'b0; X = 1'b0; RATE_WR = 1'b0; RATE_CH = '0; RATE_D = '0;
        for (int i = 0; i < 3; i++) exp_rate[i] = 4'd0;
        clear_pulses();
        #12;
        check_idle("reset");
        RN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            exp_t e;
            e.z = tbl[i].z; e.w = tbl[i].w; e.y = tbl[i].y; e.pend = tbl[i].pend;
            apply_stimulus($sformatf("table[%0d]", i), tbl[i].clear, tbl[i].x, tbl[i].wr,
                           tbl[i].ch, tbl[i].d, e);
        end
        exp_cnt = 0;
        exp_rate[0] = 4'd5;

        // maximum rate on ch0, zero on ch1
        tick("wr15", 0, 0, 1, 2'd0, 4'd15, 3'b001);
        tick("wr0", 0, 0, 1, 2'd1, 4'd0, 3'b011);
        tick("clr", 1, 0, 0, 2'd0, 4'd0, 3'b000);
        exp_rate[0] = 4'd15;
        exp_rate[1] = 4'd0;
        clear_pulses();
        count("max_rate", 16, 3'b000);
        check("max_rate.count0", 32'(pulses[0]), 32'd15);
        check("max_rate.count1", 32'(pulses[1]), 32'd0);

        // mid-period write stays pending until the wrap edge
        count("pre_mid", 6, 3'b000);
        tick("mid_wr", 0, 1, 1, 2'd0, 4'd8, 3'b001);
        count("old_rate", 8, 3'b001);
        count("mid_wrap", 1, 3'b000);
        exp_rate[0] = 4'd8;
        clear_pulses();
        count("rate8", 16, 3'b000);
        check("rate8.count0", 32'(pulses[0]), 32'd8);

        // write on the wrap edge applies at once; out-of-range channel is ignored
        count("pre_wrap", 15, 3'b000);
        tick("wrap_wr", 0, 1, 1, 2'd1, 4'd3, 3'b000);
        exp_rate[1] = 4'd3;
        clear_pulses();
        count("rate3", 4, 3'b000);
        tick("bad_ch", 0, 1, 1, 2'd3, 4'd9, 3'b000);
        count("rate3", 11, 3'b000);
        check("rate3.count0", 32'(pulses[0]), 32'd8);
        check("rate3.count1", 32'(pulses[1]), 32'd3);
        check("rate3.count2", 32'(pulses[2]), 32'd0);

        // X gating, then Clear at cnt=9 with pending and same-cycle writes
        tick("xtog1", 0, 1, 0, 2'd0, 4'd0, 3'b000);
        tick("xtog0", 0, 0, 0, 2'd0, 4'd0, 3'b000);
        tick("xtog1b", 0, 1, 0, 2'd0, 4'd0, 3'b000);
        tick("xtog0b", 0, 0, 0, 2'd0, 4'd0, 3'b000);
        count("to9", 6, 3'b000);
        tick("wr_ch2", 0, 1, 1, 2'd2, 4'd6, 3'b100);
        tick("clr9", 1, 1, 1, 2'd0, 4'd5, 3'b000);
        exp_rate[0] = 4'd5;
        exp_rate[2] = 4'd6;
        clear_pulses();
        count("after_clr", 16, 3'b000);
        check("after_clr.count0", 32'(pulses[0]), 32'd5);
        check("after_clr.count1", 32'(pulses[1]), 32'd3);
        check("after_clr.count2", 32'(pulses[2]), 32'd6);

        // asynchronous reset mid-cycle while pulses and a pending write are live
        count("pre_rst", 1, 3'b000);
        tick("pre_rst_wr", 0, 1, 1, 2'd1, 4'd9, 3'b010);
        RATE_WR = 1'b0; X = 1'b0;
        #2 RN = 1'b0;
        #1 check_idle("async_rst");
        #3 RN = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) exp_rate[i] = 4'd0;
        clear_pulses();
        count("post_rst", 16, 3'b000);
        check("post_rst.count0", 32'(pulses[0]), 32'd0);
        check("post_rst.count1", 32'(pulses[1]), 32'd0);

`ifdef BRM_PULSE_CNT_EN
        tick("pc_wr", 0, 0, 1, 2'd0, 4'd11, 3'b001);
        tick("pc_clr", 1, 0, 0, 2'd0, 4'd0, 3'b000);
        check("pcnt.clear", 32'(PCNT), 32'd0);
        exp_rate[0] = 4'd11;
        count("pc_p1", 15, 3'b000);
        tick("pc_wrap_wr", 0, 1, 1, 2'd0, 4'd2, 3'b000);
        check("pcnt.rate11", 32'(PCNT[3:0]), 32'd11);
        exp_rate[0] = 4'd2;
        count("pc_p2", 16, 3'b000);
        check("pcnt.rate2", 32'(PCNT[3:0]), 32'd2);
        check("pcnt.ch1", 32'(PCNT[7:4]), 32'd0);
        tick("pc_clr2", 1, 0, 0, 2'd0, 4'd0, 3'b000);
        check("pcnt.clear2", 32'(PCNT), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
